// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// the FSM state encoding and the default operand width.
package seq_multiplier_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage : seq_multiplier_pkg

// File: rtl/seq_multiplier.sv
// Radix-2 sequential unsigned multiplier with fixed WIDTH-cycle latency.
// The result register is held between completions so the ALU may read it combinationally.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  mul_state_e      r_state;
  mul_state_e      w_state_nxt;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_mcand;
  logic [PW-1:0]   r_result;
  logic [PW-1:0]   w_acc_sum;
  logic [WIDTH-1:0] r_mplr;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_accept;
  logic            w_run;
  logic            w_last;

  // Start is honoured only outside RUN; a DONE-cycle start chains straight into RUN.
  assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_run     = (r_state == RUN);
  assign w_last    = w_run && (r_cnt == CW'(WIDTH - 1));
  assign w_acc_sum = r_acc + (r_mplr[0] ? r_mcand : '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state so busy/done leave a flop aligned with the state
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      RUN:     w_busy_nxt = 1'b1;
      DONE:    w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Shift-add datapath; result only moves on the final RUN step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplr   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= PW'(a);
      r_mplr   <= b;
      r_cnt    <= '0;
    end else if (w_run) begin
      r_acc    <= w_acc_sum;
      r_mcand  <= r_mcand << 1;
      r_mplr   <= r_mplr >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_result <= w_acc_sum;
      end
    end
  end

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner cases plus randomized
// operands compared against a plain-arithmetic product model.
module tb_seq_multiplier;

  localparam int unsigned W  = 16;
  localparam int unsigned LAT = W + 1;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] result;
  logic           busy;
  logic           done;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] last_prod;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned p;
    p = longint'(x) * longint'(y);
    return p[2*W-1:0];
  endfunction

  task automatic pulse_start(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done (bounded); reports latency, busy cycles, result, and whether
  // result held the previous product throughout RUN.
  task automatic wait_done(input logic [2*W-1:0] hold, output int cyc, output int bcyc,
                           output logic [2*W-1:0] res, output bit stable);
    cyc = 0; bcyc = 0; stable = 1'b1; res = '0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) begin
        bcyc++;
        if (result !== hold) stable = 1'b0;
      end
      if (done) begin
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int cyc, bcyc;
    logic [2*W-1:0] res;
    bit stable;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    // Release reset and request in the same cycle: first rising edge must accept.
    rst_n = 1'b1; a = 16'h0003; b = 16'h0005; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done('0, cyc, bcyc, res, stable);
    total++; if (cyc != LAT) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", cyc, LAT); end
    total++; if (bcyc != W) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=%0d", bcyc, W); end
    total++; if (res !== 32'h0000_000F) begin bad++; $display("FAIL basic_result got=%h want=0000000f", res); end
    last_prod = 32'h0000_000F;
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL done_one_cycle done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_max;
    int cyc, bcyc;
    logic [2*W-1:0] res;
    bit stable;
    pulse_start(16'hFFFF, 16'hFFFF);
    wait_done(last_prod, cyc, bcyc, res, stable);
    total++; if (res !== 32'hFFFE_0001) begin bad++; $display("FAIL max_result got=%h want=fffe0001", res); end
    total++; if (!stable) begin bad++; $display("FAIL max_result_stable got=changed want=held %h", last_prod); end
    last_prod = 32'hFFFE_0001;
  endtask

  task automatic test_zero;
    int cyc, bcyc;
    logic [2*W-1:0] res;
    bit stable;
    pulse_start(16'h1234, 16'h0000);
    wait_done(last_prod, cyc, bcyc, res, stable);
    total++; if (cyc != LAT) begin bad++; $display("FAIL zero_latency got=%0d want=%0d", cyc, LAT); end
    total++; if (res !== 32'h0) begin bad++; $display("FAIL zero_result got=%h want=0", res); end
    last_prod = '0;
  endtask

  task automatic test_ignore_start;
    int k;
    bit seen;
    logic [2*W-1:0] res;
    pulse_start(16'h0007, 16'h0009);
    seen = 1'b0; res = '0; k = 0;
    while (k < 40 && !seen) begin
      @(negedge clk);
      k++;
      if (k == 5) begin a = 16'h0002; b = 16'h0002; start = 1'b1; end
      if (k == 7) start = 1'b0;
      if (done) begin seen = 1'b1; res = result; end
    end
    start = 1'b0;
    total++; if (k != LAT) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", k, LAT); end
    total++; if (res !== 32'h0000_003F) begin bad++; $display("FAIL ignore_result got=%h want=0000003f", res); end
    last_prod = 32'h0000_003F;
  endtask

  task automatic test_back_to_back;
    int cyc, bcyc;
    logic [2*W-1:0] res1, res2, exp1;
    bit stable;
    logic [W-1:0] x, y;
    x = W'($urandom); y = W'($urandom);
    exp1 = model_mul(x, y);
    pulse_start(x, y);
    wait_done(last_prod, cyc, bcyc, res1, stable);
    total++; if (res1 !== exp1) begin bad++; $display("FAIL b2b_first got=%h want=%h", res1, exp1); end
    // Still in the DONE cycle: chain a new operation.
    a = 16'h0010; b = 16'h0010; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(exp1, cyc, bcyc, res2, stable);
    total++; if (cyc != LAT) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", cyc, LAT); end
    total++; if (res2 !== 32'h0000_0100) begin bad++; $display("FAIL b2b_second got=%h want=00000100", res2); end
    total++; if (!stable) begin bad++; $display("FAIL b2b_hold got=changed want=held %h", exp1); end
    last_prod = 32'h0000_0100;
  endtask

  task automatic test_reset_mid;
    int dones, busys;
    pulse_start(16'hABCD, 16'h1357);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", done); end
    total++; if (result !== '0) begin bad++; $display("FAIL rstmid_result got=%h want=0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0; busys = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busys++;
    end
    total++; if (dones != 0 || busys != 0) begin bad++; $display("FAIL rstmid_quiet done_cnt=%0d busy_cnt=%0d want 0/0", dones, busys); end
    last_prod = '0;
  endtask

  task automatic test_random;
    int cyc, bcyc;
    logic [2*W-1:0] res, exp;
    bit stable;
    logic [W-1:0] x, y;
    for (int i = 0; i < 12; i++) begin
      x = W'($urandom); y = W'($urandom);
      if (i == 3) x = '1;
      if (i == 7) y = 16'h0001;
      exp = model_mul(x, y);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pulse_start(x, y);
      wait_done(last_prod, cyc, bcyc, res, stable);
      total++;
      if (res !== exp || cyc != LAT || bcyc != W || !stable) begin
        bad++;
        $display("FAIL rand_%0d a=%h b=%h got=%h want=%h lat=%0d/%0d busy=%0d/%0d stable=%b",
                 i, x, y, res, exp, cyc, LAT, bcyc, W, stable);
      end
      last_prod = exp;
    end
  endtask

  initial begin
    last_prod = '0;
    test_reset();
    test_max();
    test_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_multiplier

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand width in bits; the product is 2*WIDTH bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a multiply with the current a and b.
REQ-005 SHALL have port a  input  WIDTH  unsigned multiplicand; the ALU supplies the magnitude of operand 1.
REQ-006 SHALL have port b  input  WIDTH  unsigned multiplier; the ALU supplies the magnitude of operand 2.
REQ-007 SHALL have port result  output  2*WIDTH  unsigned product, which feeds the ALU mulresult input.
REQ-008 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking result valid; the state machine uses it to raise exec2.

Function
REQ-010 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-011 SHALL accept start only in IDLE or DONE; on acceptance it SHALL latch a and b, clear the accumulator and iteration count, and enter RUN.
REQ-012 SHALL ignore start while in RUN, with no effect on operands, count or result.
REQ-013 SHALL perform one radix-2 shift-add step per RUN cycle: if the current multiplier LSB is 1, add the shifted multiplicand to the 2*WIDTH accumulator; then shift the multiplier right and the multiplicand left.
REQ-014 SHALL spend exactly WIDTH cycles in RUN, with no early termination on zero operands (fixed latency).
REQ-015 SHALL, on the edge that ends the last RUN cycle, load result from the accumulator and enter DONE.
REQ-016 SHALL hold done high for exactly the one cycle spent in DONE, which is cycle WIDTH+1 after the accepting edge.
REQ-017 SHALL leave DONE for RUN if start is high in that cycle (back-to-back operation), and for IDLE otherwise.
REQ-018 SHALL drive busy high exactly when in RUN.
REQ-019 SHALL keep result stable from its load until the load that completes the next multiply, including throughout RUN, because the ALU reads it combinationally.
REQ-020 SHALL compute the full 2*WIDTH-bit product with no truncation or overflow; the maximum is (2^WIDTH-1)^2.
REQ-021 SHALL leave sign handling to the ALU; operands are treated strictly as unsigned.

Reset
REQ-022 SHALL, while rst_n is low and regardless of clock, force state to IDLE, result to 0, busy to 0, done to 0, and clear the accumulator, operands and count.
REQ-023 SHALL abandon any multiply in progress when reset is asserted mid-operation, with no done pulse and result reading 0.
REQ-024 SHALL, after rst_n deasserts, accept start on the first rising edge.

Structure
REQ-025 SHALL place the state enumeration (IDLE, RUN, DONE) and the default WIDTH constant in the shared CPU package.
REQ-026 SHALL be a single module: counter, accumulator and FSM with no sub-module; the iteration counter is $clog2(WIDTH+1) bits.

Verification
REQ-027 SHALL cover: a=0x0003, b=0x0005, start pulsed -> busy high for 16 cycles, done at cycle 17, result=0x0000000F.
REQ-028 SHALL cover: a=0xFFFF, b=0xFFFF -> result=0xFFFE0001 at done.
REQ-029 SHALL cover: a=0x1234, b=0x0000 -> result=0x00000000 after the full 17-cycle latency, with no early done.
REQ-030 SHALL cover: start re-asserted with a=0x0002, b=0x0002 during RUN of 0x0007*0x0009 -> ignored; result=0x0000003F.
REQ-031 SHALL cover: start held high in the DONE cycle with new operands 0x0010, 0x0010 -> first done yields the first product; the next done arrives 17 cycles later with result=0x00000100.
REQ-032 SHALL cover: rst_n pulsed low at RUN cycle 8 -> immediately state IDLE, busy=0, done=0, result=0, and no done follows.
